// File: rtl/fmps_link_tx.sv
// FMPS packet transmitter: send requests -> 2-word AXI-Stream packets (header, data+TLAST), stamped with FA cycle count.
// Latency: request to TVALID is 2 cycles from an empty idle block; back-to-back packets leave no idle gap.
// Backpressure: one-deep pending entry; requests arriving while it is full and not being consumed are dropped with dropStrobe.
// Optional build macro FMPS_LINK_TX_DROP_COUNT_EN enables the saturating dropCount counter (tied to 0 otherwise).
module fmps_link_tx #(
   parameter int          INDEX_WIDTH         = 5,
   parameter logic [15:0] HEADER_MAGIC        = 16'hB6CF,
   parameter int          CYCLE_COUNTER_WIDTH = 8
) (
   input  logic                   auClk,
   input  logic                   auReset,
   input  logic                   auChannelUp,
   input  logic                   auFAstrobe,
   input  logic                   auInhibit,
   input  logic                   sendStrobe,
   input  logic [INDEX_WIDTH-1:0] sendIndex,
   input  logic [15:0]            sendStatus,
   input  logic [1:0]             sendInvalid,
   output logic [31:0]            TDATA,
   output logic                   TVALID,
   output logic                   TLAST,
   input  logic                   TREADY,
   output logic                   busy,
   output logic                   dropStrobe,
   output logic [15:0]            dropCount
);

   typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

   state_t                         state;
   logic [CYCLE_COUNTER_WIDTH-1:0] cycleCount;
   logic [CYCLE_COUNTER_WIDTH-1:0] cycleNext;

   logic                           pendValid;
   logic [INDEX_WIDTH-1:0]         pendIndex;
   logic [15:0]                    pendStatus;
   logic [1:0]                     pendInvalid;
   logic [CYCLE_COUNTER_WIDTH-1:0] pendStamp;

   // Data word of the packet in flight, parked here while the header is on the bus.
   logic [31:0]                    dataWord;

   logic                           pendConsume;
   logic                           sendAccept;
   logic                           sendDrop;

   // Header: magic in the top half, index field at bit 10, everything else zero.
   function automatic logic [31:0] headerFmt(input logic [INDEX_WIDTH-1:0] idx);
      logic [31:0] w;
      w = {HEADER_MAGIC, 16'h0000};
      w[10 +: INDEX_WIDTH] = idx;
      return w;
   endfunction

   // Data: invalid flags on top, index at bit 24, status in the middle, stamp in the low byte.
   function automatic logic [31:0] dataFmt(
      input logic [INDEX_WIDTH-1:0]         idx,
      input logic [15:0]                    status,
      input logic [1:0]                     inv,
      input logic [CYCLE_COUNTER_WIDTH-1:0] stamp
   );
      logic [31:0] w;
      w = 32'h0;
      w[31:30] = inv;
      w[24 +: INDEX_WIDTH] = idx;
      w[23:8] = status;
      w[0 +: CYCLE_COUNTER_WIDTH] = stamp;
      return w;
   endfunction

   // Stamp uses the counter value including a coincident FA strobe.
   assign cycleNext   = cycleCount + CYCLE_COUNTER_WIDTH'(auFAstrobe);
   // The pending entry leaves when the output side is idle or the data word is being accepted.
   assign pendConsume = pendValid && ((state == IDLE) || ((state == DATA) && TREADY));
   assign sendAccept  = sendStrobe && auChannelUp && !auInhibit && (!pendValid || pendConsume);
   assign sendDrop    = sendStrobe && !sendAccept;
   assign busy        = (state != IDLE) || pendValid;

   // FA cycle counter, free-running modulo its width.
   always_ff @(posedge auClk) begin
      if (auReset) cycleCount <= '0;
      else         cycleCount <= cycleNext;
   end

   // One-deep pending entry; a capture in the same cycle as a consume refills it.
   always_ff @(posedge auClk) begin
      if (auReset) begin
         pendValid   <= 1'b0;
         pendIndex   <= '0;
         pendStatus  <= '0;
         pendInvalid <= '0;
         pendStamp   <= '0;
      end else if (sendAccept) begin
         pendValid   <= 1'b1;
         pendIndex   <= sendIndex;
         pendStatus  <= sendStatus;
         pendInvalid <= sendInvalid;
         pendStamp   <= cycleNext;
      end else if (pendConsume) begin
         pendValid   <= 1'b0;
      end
   end

   // Drop indication, one cycle after the rejected request.
   always_ff @(posedge auClk) begin
      if (auReset) dropStrobe <= 1'b0;
      else         dropStrobe <= sendDrop;
   end

`ifdef FMPS_LINK_TX_DROP_COUNT_EN
   // Saturating drop counter, cleared only by reset.
   always_ff @(posedge auClk) begin
      if (auReset)                              dropCount <= 16'h0000;
      else if (sendDrop && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
   end
`else
   assign dropCount = 16'h0000;
`endif

   // Packet FSM with registered stream outputs; TDATA/TVALID only move on a handshake or a new packet start.
   always_ff @(posedge auClk) begin
      if (auReset) begin
         state    <= IDLE;
         TVALID   <= 1'b0;
         TLAST    <= 1'b0;
         TDATA    <= 32'h0;
         dataWord <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (pendValid) begin
                  TDATA    <= headerFmt(pendIndex);
                  dataWord <= dataFmt(pendIndex, pendStatus, pendInvalid, pendStamp);
                  TVALID   <= 1'b1;
                  TLAST    <= 1'b0;
                  state    <= HEADER;
               end
            end
            HEADER: begin
               if (TREADY) begin
                  TDATA <= dataWord;
                  TLAST <= 1'b1;
                  state <= DATA;
               end
            end
            DATA: begin
               if (TREADY) begin
                  if (pendValid) begin
                     TDATA    <= headerFmt(pendIndex);
                     dataWord <= dataFmt(pendIndex, pendStatus, pendInvalid, pendStamp);
                     TLAST    <= 1'b0;
                     state    <= HEADER;
                  end else begin
                     TDATA  <= 32'h0;
                     TVALID <= 1'b0;
                     TLAST  <= 1'b0;
                     state  <= IDLE;
                  end
               end
            end
            default: begin
               TVALID <= 1'b0;
               TLAST  <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fmps_link_tx.md
Name: fmps_link_tx

Overview:
- FMPS packet transmitter for one Aurora FMPS link (CCW or CW); the sending end of the link that the FMPS readout path consumes.
- Takes single-cycle send requests carrying an FMPS index and 16-bit status, and emits 2-word AXI-Stream packets: a header word, then a data word with TLAST.
- Stamps each packet with the FA cycle counter.
- One instance per link direction, on the Aurora user clock.

Parameters:
- INDEX_WIDTH, 5, FMPS index width; header index at bits [10+INDEX_WIDTH-1:10], data index at [24+INDEX_WIDTH-1:24]; legal 1..5.
- HEADER_MAGIC, 16'hB6CF, value placed in header bits [31:16].
- CYCLE_COUNTER_WIDTH, 8, width of FA cycle counter and data bits [7:0]; legal 1..8.

Ports:
- auClk  input  1  Aurora user clock; sole clock.
- auReset  input  1  synchronous, active-high reset.
- auChannelUp  input  1  link up; requests are dropped while low.
- auFAstrobe  input  1  single-cycle FA strobe; increments cycle counter.
- auInhibit  input  1  high: new requests are dropped.
- sendStrobe  input  1  single-cycle send request.
- sendIndex  input  INDEX_WIDTH  FMPS index of the request.
- sendStatus  input  16  FMPS status payload.
- sendInvalid  input  2  [1]=invalidFMPS2CC, [0]=invalidCC2CC flags.
- TDATA  output  32  stream data.
- TVALID  output  1  stream valid.
- TLAST  output  1  high on the data word.
- TREADY  input  1  stream ready.
- busy  output  1  high when state != IDLE or a pending entry is held.
- dropStrobe  output  1  one-cycle pulse per dropped request.
- dropCount  output  16  dropped-request counter (see Optional Feature).

Behaviour:
- Reset values: TVALID=0, TLAST=0, TDATA=0, busy=0, dropStrobe=0, dropCount=0, cycle counter=0, pending entry cleared, state=IDLE.
- Reset mid-packet: TVALID goes low on the next edge; the packet is abandoned with no TLAST.
- Cycle counter: +1 per auFAstrobe, wraps modulo 2^CYCLE_COUNTER_WIDTH.
- Stamp value: counter's next value, i.e. cnt+1 if auFAstrobe is high in the same cycle, else cnt.
- Pending entry: one-deep holding register {index, status, invalid, stamp}.
- Request capture: the pending entry is loaded when sendStrobe && auChannelUp && !auInhibit && (!pendValid || pendConsume).
- Dropped request: any other sendStrobe, i.e. channel down, inhibited, or pending full and not consumed. Response is dropStrobe=1 for one cycle after; the request has no other effect.
- pendConsume: the FSM transfers the pending entry into the output registers and enters HEADER.
- FSM states: IDLE, HEADER, DATA.
- IDLE: if pendValid, consume and go to HEADER (TVALID=1 on the next edge). Request-to-TVALID latency is 2 cycles from an empty idle block.
- HEADER: TDATA = {HEADER_MAGIC, 1'b0, index at [14:10] (zero-extended field), 10'b0}, TLAST=0. On TREADY go to DATA.
- DATA: TDATA = {invalid[1:0], 1'b0, index at [28:24], status[15:0] at [23:8], stamp at [7:0]}, TLAST=1. On TREADY:
  - if pendValid, consume and go to HEADER (back-to-back, no idle gap);
  - else go to IDLE with TVALID=0.
- AXI rules: TVALID and TDATA stay stable while TVALID && !TREADY. auChannelUp or auInhibit falling or rising mid-packet does not truncate the packet in flight.
- Unused bits are zero.

Optional Feature:
- Macro: FMPS_LINK_TX_DROP_COUNT_EN.
- Defined: dropCount increments on every drop, saturates at 16'hFFFF, and is cleared only by auReset.
- Undefined: dropCount is tied to 0 and no counter logic exists. dropStrobe is present in both builds.

Test Plan:
- Reset, auChannelUp=1, TREADY=1; sendStrobe index=3, status=16'hCACA, invalid=0 after 2 FA strobes. Required stream: header 32'hB6CF0C00, then data 32'h03CACA02 with TLAST, TVALID high for exactly 2 cycles.
- TREADY toggled at 50% random over 100 packets. Every packet is exactly 2 words, TDATA is stable while stalled, and the index sequence is preserved.
- Three sendStrobes on consecutive cycles while in DATA with TREADY=0: 1st held pending, 2nd and 3rd dropped. Expect dropStrobe twice, dropCount=2 with the macro, 0 without.
- auInhibit=1 or auChannelUp=0 with sendStrobe: no TVALID, one dropStrobe each. Deassert and resend: the packet goes out normally.
- 256 FA strobes, then sendStrobe coincident with the 257th. Stamp = 8'h01 (wrap); with the macro, saturation reached after 65536 forced drops stays at 16'hFFFF.
- auReset asserted while the header is stalled (TREADY=0). TVALID=0 next edge, busy=0, counter=0, and the next request emits a clean 2-word packet with stamp 0.
